bawsss_mem_arbiter: RTL and testbench

Shares one single-port, fixed-latency unified memory between the bawsss_cpu instruction-fetch port and its data (load/store) port. Each access is a req/ack transaction; the arbiter grants one requester at a time and counts out the memory latency. Data has priority, with a streak limit so fetch cannot starve. Sits between bawsss_cpu and the unified memory at the top level.

---
 rtl/bawsss_mem_pkg.sv | 10 +
 rtl/bawsss_lat_counter.sv | 25 ++
 rtl/bawsss_mem_arbiter.sv | 115 +++++++++++
 tb/tb_bawsss_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bawsss_mem_pkg.sv
// Shared types and default timing parameters for the bawsss unified-memory arbiter.
package bawsss_mem_pkg;

    localparam int DEF_LATENCY      = 2;
    localparam int DEF_MAX_D_STREAK = 3;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/bawsss_lat_counter.sv
// Loadable down-counter that stops at zero; times out one memory access.
module bawsss_lat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/bawsss_mem_arbiter.sv
// Shares one fixed-latency single-port memory between the cpu fetch and data ports.
// Data wins contention until its streak limit is reached, then fetch gets one grant.
import bawsss_mem_pkg::*;

module bawsss_mem_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int LATENCY      = DEF_LATENCY,
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  m_en,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  busy
);

    localparam logic [3:0] LOAD_VAL   = 4'(LATENCY - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t     state, state_nxt;
    owner_t     grant_own;
    logic       grant;
    logic [3:0] streak;
    logic [3:0] cnt;
    logic       cnt_zero;
    logic       we_q;

    bawsss_lat_counter #(.WIDTH(4)) u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (grant),
        .load_val (LOAD_VAL),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // Grants only happen from IDLE, which gives the mandatory bubble between accesses.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_own = OWN_D;
        case (state)
            IDLE: begin
                if (d_req && !(i_req && streak == STREAK_MAX)) begin
                    grant     = 1'b1;
                    grant_own = OWN_D;
                    state_nxt = BUSY_D;
                end else if (i_req) begin
                    grant     = 1'b1;
                    grant_own = OWN_I;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (cnt_zero) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The streak only grows while fetch is actually waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            streak  <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            we_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                if (grant_own == OWN_D) begin
                    m_addr  <= d_addr;
                    m_wdata <= d_wdata;
                    we_q    <= d_we;
                    if (!i_req) begin
                        streak <= '0;
                    end else if (streak != STREAK_MAX) begin
                        streak <= streak + 4'd1;
                    end
                end else begin
                    m_addr  <= i_addr;
                    m_wdata <= '0;
                    we_q    <= 1'b0;
                    streak  <= '0;
                end
            end
        end
    end

    assign busy    = (state != IDLE);
    assign m_en    = busy;
    assign m_we    = busy && we_q;
    assign i_ack   = (state == BUSY_I) && cnt_zero;
    assign d_ack   = (state == BUSY_D) && cnt_zero;
    assign i_rdata = i_ack ? m_rdata : '0;
    assign d_rdata = (d_ack && !we_q) ? m_rdata : '0;

endmodule

// File: tb/tb_bawsss_mem_arbiter.sv
// Self-checking bench for bawsss_mem_arbiter with a small memory model and an ack scoreboard.
module tb_bawsss_mem_arbiter;

    typedef struct {
        bit          isData;
        logic [15:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        busy;

    int   checks = 0;
    int   failures = 0;
    exp_t sbQ[$];
    exp_t e;
    logic [36:0] obsV, expV;

    logic [15:0] mem [0:4095];
    bit          preloaded = 1'b0;

    bawsss_mem_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on every clock of a store access.
    assign m_rdata = mem[m_addr[11:0]];
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int a = 0; a < 4096; a++) mem[a] <= 16'h0000;
            mem[12'h010] <= 16'hA5A5;
            mem[12'h020] <= 16'h1111;
            preloaded <= 1'b1;
        end else if (m_en && m_we) begin
            mem[m_addr[11:0]] <= m_wdata;
        end
    end

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            i_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
            i_addr = 16'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
            #1;
            checks++;
            if ({m_en, m_we, m_addr, m_wdata, i_ack, d_ack, busy, i_rdata, d_rdata} !== '0) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d got m_en=%b m_we=%b m_addr=%h m_wdata=%h i_ack=%b d_ack=%b busy=%b expected all 0",
                         c, m_en, m_we, m_addr, m_wdata, i_ack, d_ack, busy);
            end
        end
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0030;
        @(posedge clk);
        #2;
        checks++;
        if (m_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL async_pre got m_en=%b busy=%b expected 1 1", m_en, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({m_en, m_we, m_addr, i_ack, busy} !== '0) begin
            failures++;
            $display("FAIL async_reset got m_en=%b m_we=%b m_addr=%h i_ack=%b busy=%b expected all 0",
                     m_en, m_we, m_addr, i_ack, busy);
        end
        @(negedge clk);
        i_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (i_ack !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_abort got i_ack=%b busy=%b expected 0 0", i_ack, busy);
        end
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0010;
        sbQ.push_back('{isData: 1'b0, rdata: 16'hA5A5});
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            obsV = {m_en, m_we, m_addr, m_wdata, busy, i_ack, d_ack};
            expV = {(c <= 2), 1'b0, 16'h0010, 16'h0000, (c <= 2), (c == 2), 1'b0};
            checks++;
            if (obsV !== expV) begin
                failures++;
                $display("FAIL fetch_cycle%0d got %h expected %h", c, obsV, expV);
            end
            if (i_ack || d_ack) begin
                checks++;
                e = sbQ.pop_front();
                if ({d_ack, i_ack, (d_ack ? d_rdata : i_rdata)} !== {e.isData, !e.isData, e.rdata}) begin
                    failures++;
                    $display("FAIL fetch_sb got d_ack=%b rdata=%h expected d=%b rdata=%h",
                             d_ack, d_ack ? d_rdata : i_rdata, e.isData, e.rdata);
                end
            end
            if (c == 2) i_req = 1'b0;
        end
    endtask

    task automatic test_contention();
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0020;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
        sbQ.push_back('{isData: 1'b1, rdata: 16'h0000});
        sbQ.push_back('{isData: 1'b0, rdata: 16'h1111});
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            obsV = {m_en, m_we, m_addr, m_wdata, busy, i_ack, d_ack};
            case (c)
                1:       expV = {1'b1, 1'b1, 16'h0100, 16'h1234, 1'b1, 1'b0, 1'b0};
                2:       expV = {1'b1, 1'b1, 16'h0100, 16'h1234, 1'b1, 1'b0, 1'b1};
                3:       expV = {1'b0, 1'b0, 16'h0100, 16'h1234, 1'b0, 1'b0, 1'b0};
                4:       expV = {1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0};
                5:       expV = {1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b1, 1'b0};
                default: expV = {1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0};
            endcase
            checks++;
            if (obsV !== expV) begin
                failures++;
                $display("FAIL contention_cycle%0d got %h expected %h", c, obsV, expV);
            end
            if (i_ack || d_ack) begin
                checks++;
                e = sbQ.pop_front();
                if ({d_ack, i_ack, (d_ack ? d_rdata : i_rdata)} !== {e.isData, !e.isData, e.rdata}) begin
                    failures++;
                    $display("FAIL contention_sb got d_ack=%b rdata=%h expected d=%b rdata=%h",
                             d_ack, d_ack ? d_rdata : i_rdata, e.isData, e.rdata);
                end
            end
            if (c == 2) d_req = 1'b0;
            if (c == 5) i_req = 1'b0;
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'hBEEF;
        sbQ.push_back('{isData: 1'b1, rdata: 16'h0000});
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (d_ack !== (c == 2 || c == 5)) begin
                failures++;
                $display("FAIL wr_ack_cycle%0d got d_ack=%b expected %b", c, d_ack, (c == 2 || c == 5));
            end
            if (i_ack || d_ack) begin
                checks++;
                e = sbQ.pop_front();
                if ({d_ack, i_ack, (d_ack ? d_rdata : i_rdata)} !== {e.isData, !e.isData, e.rdata}) begin
                    failures++;
                    $display("FAIL wr_sb got d_ack=%b rdata=%h expected d=%b rdata=%h",
                             d_ack, d_ack ? d_rdata : i_rdata, e.isData, e.rdata);
                end
            end
            if (c == 2) d_req = 1'b0;
            if (c == 3) begin
                d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200; d_wdata = 16'h0000;
                sbQ.push_back('{isData: 1'b1, rdata: 16'hBEEF});
            end
            if (c == 5) d_req = 1'b0;
        end
    endtask

    task automatic test_fairness();
        int lastIAck = -1;
        int iAcks = 0;
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) sbQ.push_back('{isData: 1'b1, rdata: 16'h1234});
            sbQ.push_back('{isData: 1'b0, rdata: 16'hA5A5});
        end
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (i_ack || d_ack) begin
                checks++;
                if (sbQ.size() == 0) begin
                    failures++;
                    $display("FAIL fair_extra_ack cycle=%0d got i_ack=%b d_ack=%b expected none", c, i_ack, d_ack);
                end else begin
                    e = sbQ.pop_front();
                    if ({d_ack, i_ack, (d_ack ? d_rdata : i_rdata)} !== {e.isData, !e.isData, e.rdata}) begin
                        failures++;
                        $display("FAIL fair_order cycle=%0d got d_ack=%b rdata=%h expected d=%b rdata=%h",
                                 c, d_ack, d_ack ? d_rdata : i_rdata, e.isData, e.rdata);
                    end
                end
            end
            if (i_ack) begin
                iAcks++;
                if (lastIAck >= 0) begin
                    checks++;
                    if (c - lastIAck != 12) begin
                        failures++;
                        $display("FAIL fair_period got %0d cycles expected 12", c - lastIAck);
                    end
                end
                lastIAck = c;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        checks++;
        if (sbQ.size() != 0 || iAcks != 2) begin
            failures++;
            $display("FAIL fair_complete got pending=%0d i_acks=%0d expected 0 and 2", sbQ.size(), iAcks);
            sbQ.delete();
        end
    endtask

    task automatic test_reset_mid_access();
        bit seen = 1'b0;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (m_en !== 1'b0 || d_ack !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got m_en=%b d_ack=%b busy=%b expected 0 0 0", m_en, d_ack, busy);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (d_ack !== 1'b0 || m_en !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset_hold got d_ack=%b m_en=%b expected 0 0", d_ack, m_en);
            end
        end
        rst = 1'b1;
        sbQ.push_back('{isData: 1'b1, rdata: 16'hBEEF});
        for (int c = 1; c <= 6 && !seen; c++) begin
            @(negedge clk);
            if (i_ack || d_ack) begin
                seen = 1'b1;
                checks++;
                e = sbQ.pop_front();
                if ({d_ack, i_ack, (d_ack ? d_rdata : i_rdata)} !== {e.isData, !e.isData, e.rdata} || c != 2) begin
                    failures++;
                    $display("FAIL reissue_sb cycle=%0d got d_ack=%b rdata=%h expected cycle 2 d=%b rdata=%h",
                             c, d_ack, d_ack ? d_rdata : i_rdata, e.isData, e.rdata);
                end
                d_req = 1'b0;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL reissue_timeout got no d_ack expected d_ack within 6 cycles");
            d_req = 1'b0;
            sbQ.delete();
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_write_read();
        test_fairness();
        test_reset_mid_access();
        @(negedge clk);
        checks++;
        if (sbQ.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d pending expected 0", sbQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
